// File: rtl/rtc_poll_scheduler.sv
// RTC poll scheduler: reads RTC registers 0x00-0x06 once per tick and commits them atomically.
// Optional macro RTC_BCD_CHECK_EN rejects commits whose shadow bytes are not valid BCD.
module rtc_poll_scheduler #(
  parameter int POLL_DIV  = 50000000,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       en,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_done,
  input  logic       rd_nack,
  input  logic [7:0] rd_data,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] day,
  output logic [7:0] date,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       valid,
  output logic       busy,
  output logic       err
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_DONE,
    STORE,
    COMMIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [2:0]      idx;
  logic [RW-1:0]   retry;
  logic [RW-1:0]   retry_nxt;
  logic [7:0]      shadow [7];

  assign tick      = (cnt == CW'(POLL_DIV - 1));
  assign retry_nxt = retry + 1'b1;
  assign busy      = (state != IDLE) && (state != WAIT_TICK);

`ifdef RTC_BCD_CHECK_EN
  function automatic logic nib_ok(input logic [7:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
  endfunction

  logic bcd_ok;
  // CH bit of seconds and 12/24h mode bits of hours are not BCD digits.
  assign bcd_ok = nib_ok(shadow[0] & 8'h7F) && nib_ok(shadow[1]) &&
                  nib_ok(shadow[2] & 8'h3F) && nib_ok(shadow[3]) &&
                  nib_ok(shadow[4]) && nib_ok(shadow[5]) &&
                  nib_ok(shadow[6]);
`endif

  // Poll-period counter; parked at zero while polling is disabled.
  always_ff @(posedge clk_50mhz) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Read sequencer: issue, retry on NACK, shadow bytes, commit all at once.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      retry   <= '0;
      rd_req  <= 1'b0;
      rd_addr <= 8'h00;
      valid   <= 1'b0;
      err     <= 1'b0;
      sec     <= 8'h00;
      min     <= 8'h00;
      hour    <= 8'h00;
      day     <= 8'h00;
      date    <= 8'h00;
      month   <= 8'h00;
      year    <= 8'h00;
      for (int i = 0; i < 7; i++) shadow[i] <= 8'h00;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) state <= WAIT_TICK;
        end
        WAIT_TICK: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick) begin
            idx   <= '0;
            retry <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          rd_req  <= 1'b1;
          rd_addr <= {5'd0, idx};
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (rd_done) begin
            rd_req <= 1'b0;
            if (!rd_nack) begin
              shadow[idx] <= rd_data;
              retry       <= '0;
              state       <= STORE;
            end else if (retry_nxt <= RW'(MAX_RETRY)) begin
              retry <= retry_nxt;
              state <= ISSUE;
            end else begin
              err   <= 1'b1;
              state <= WAIT_TICK;
            end
          end
        end
        STORE: begin
          if (idx < 3'd6) begin
            idx   <= idx + 3'd1;
            state <= ISSUE;
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
`ifdef RTC_BCD_CHECK_EN
          if (bcd_ok) begin
            sec   <= shadow[0];
            min   <= shadow[1];
            hour  <= shadow[2];
            day   <= shadow[3];
            date  <= shadow[4];
            month <= shadow[5];
            year  <= shadow[6];
            valid <= 1'b1;
          end else begin
            err <= 1'b1;
          end
`else
          sec   <= shadow[0];
          min   <= shadow[1];
          hour  <= shadow[2];
          day   <= shadow[3];
          date  <= shadow[4];
          month <= shadow[5];
          year  <= shadow[6];
          valid <= 1'b1;
`endif
          state <= WAIT_TICK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_poll_scheduler.sv
// Bench for rtc_poll_scheduler: table of poll scenarios plus a
// scoreboard of expected addresses and commits, and a reset corner case.
module tb_rtc_poll_scheduler;

  localparam int PD = 16;
  localparam int MR = 3;

  logic       clk_50mhz = 1'b0;
  logic       rst, en, rd_done, rd_nack;
  logic [7:0] rd_data;
  logic       rd_req, valid, busy, err;
  logic [7:0] rd_addr, sec, min, hour, day, date, month, year;

  always #10 clk_50mhz = ~clk_50mhz;

  rtc_poll_scheduler #(.POLL_DIV(PD), .MAX_RETRY(MR)) dut (
    .clk_50mhz(clk_50mhz),
    .rst(rst),
    .en(en),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_done(rd_done),
    .rd_nack(rd_nack),
    .rd_data(rd_data),
    .sec(sec),
    .min(min),
    .hour(hour),
    .day(day),
    .date(date),
    .month(month),
    .year(year),
    .valid(valid),
    .busy(busy),
    .err(err)
  );

  typedef struct {
    logic [55:0] data;
    int          nack_addr;
    int          nack_cnt;
    int          delay;
    bit          exp_valid;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [5];
  int          checks = 0;
  int          failures = 0;
  int          vcount = 0;
  int          addr_q [$];
  logic [55:0] commit_q [$];
  logic [55:0] model_out = '0;
  bit          model_err = 1'b0;

  function automatic logic [55:0] outs();
    return {year, month, date, day, hour, min, sec};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Commit monitor: every valid pulse must match the oldest expected commit.
  always @(negedge clk_50mhz) begin
    if (valid) begin
      vcount++;
      checks++;
      if (commit_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid actual=%h required=none", outs());
      end else begin
        logic [55:0] e;
        e = commit_q.pop_front();
        if (outs() !== e) begin
          failures++;
          $display("FAIL commit_data actual=%h required=%h", outs(), e);
        end
      end
    end
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * PD + 64; i++) begin
      @(negedge clk_50mhz);
      if (rd_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve(input int a, input logic [7:0] d, input bit nack,
                       input int delay);
    repeat (delay) @(negedge clk_50mhz);
    if (delay > 0) chk("req_hold", {rd_req, rd_addr}, {1'b1, a[7:0]});
    rd_done = 1'b1;
    rd_nack = nack;
    rd_data = nack ? 8'hEE : d;
    @(negedge clk_50mhz);
    rd_done = 1'b0;
    rd_nack = 1'b0;
    rd_data = 8'h00;
    chk("req_drop", rd_req, 0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int nacks, reps, a, lat;
    bit ok, nk;
    nacks = 0;
    vcount = 0;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == v.nack_addr) begin
        reps = (v.nack_cnt <= MR) ? v.nack_cnt + 1 : MR + 1;
        repeat (reps) addr_q.push_back(i);
        if (v.nack_cnt > MR) break;
      end else begin
        addr_q.push_back(i);
      end
    end
    if (v.exp_valid) commit_q.push_back(v.data);
    while (addr_q.size() > 0) begin
      wait_req(ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL req_timeout vec=%0d actual=none required=%0d",
                 n, addr_q[0]);
        addr_q.delete();
        break;
      end
      a = addr_q.pop_front();
      chk("rd_addr", rd_addr, a);
      chk("busy_seq", busy, 1);
      nk = (a == v.nack_addr) && (nacks < v.nack_cnt);
      if (nk) nacks++;
      serve(a, v.data[8*a +: 8], nk, v.delay);
    end
    if (ok && v.exp_valid) begin
      lat = 1;
      while (!valid && lat < 10) begin
        @(negedge clk_50mhz);
        lat++;
      end
      chk("commit_latency", lat, 3);
    end
    repeat (4) @(negedge clk_50mhz);
    if (v.exp_valid) model_out = v.data;
    model_err = model_err | v.exp_err;
    chk("valid_count", vcount, v.exp_valid);
    chk("err", err, model_err);
    chk("outputs", outs(), model_out);
    chk("commit_q_empty", commit_q.size(), 0);
    commit_q.delete();
  endtask

  initial begin
    bit ok;
    int a, stray;
    vecs[0] = '{{8'h24, 8'h08, 8'h15, 8'h03, 8'h12, 8'h59, 8'h30},
                -1, 0, 0, 1'b1, 1'b0};
    vecs[1] = '{{8'h25, 8'h09, 8'h16, 8'h04, 8'h12, 8'h00, 8'h31},
                2, 2, 0, 1'b1, 1'b0};
    vecs[2] = '{{8'h26, 8'h11, 8'h20, 8'h05, 8'h07, 8'h10, 8'h45},
                -1, 0, 20, 1'b1, 1'b0};
`ifdef RTC_BCD_CHECK_EN
    vecs[3] = '{{8'h27, 8'h12, 8'h31, 8'h06, 8'h23, 8'h5A, 8'h00},
                -1, 0, 0, 1'b0, 1'b1};
`else
    vecs[3] = '{{8'h27, 8'h12, 8'h31, 8'h06, 8'h23, 8'h5A, 8'h00},
                -1, 0, 0, 1'b1, 1'b0};
`endif
    vecs[4] = '{{8'h28, 8'h01, 8'h02, 8'h07, 8'h09, 8'h30, 8'h15},
                4, 4, 0, 1'b0, 1'b1};

    rst = 1'b1;
    en = 1'b0;
    rd_done = 1'b0;
    rd_nack = 1'b0;
    rd_data = 8'h00;
    repeat (3) @(negedge clk_50mhz);
    chk("rst_outputs", outs(), 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    en = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    for (int i = 0; i < 4; i++) addr_q.push_back(i);
    while (addr_q.size() > 1) begin
      wait_req(ok);
      if (!ok) break;
      a = addr_q.pop_front();
      chk("rst_seq_addr", rd_addr, a);
      serve(a, 8'h11, 1'b0, 0);
    end
    wait_req(ok);
    chk("rst_seq_reach", ok, 1);
    chk("rst_seq_addr3", rd_addr, 3);
    addr_q.delete();
    rst = 1'b1;
    @(negedge clk_50mhz);
    chk("abort_rd_req", rd_req, 0);
    chk("abort_outputs", outs(), 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    chk("abort_valid", valid, 0);
    en = 1'b0;
    @(negedge clk_50mhz);
    rst = 1'b0;
    stray = 0;
    repeat (3 * PD) begin
      @(negedge clk_50mhz);
      if (rd_req || busy || valid) stray++;
    end
    chk("idle_after_abort", stray, 0);
    chk("no_commit_after_abort", outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
